soc_noc_loopback: RTL and testbench

SOC_NOC_LOOPBACK -- requirements
Module: soc_noc_loopback

---
 rtl/soc_noc_loopback_if.sv | 32 +++
 rtl/soc_noc_loopback.sv | 118 +++++++++++
 tb/tb_soc_noc_loopback.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/soc_noc_loopback_if.sv
// -----------------------------------------------------------------------------
// soc_noc_loopback_if
// Flit handshake bundle between a tile NoC port and the loopback block.
//   in_flit/in_last/in_valid   : tile -> loopback flits, in_ready back-pressure
//   out_flit/out_last/out_valid: loopback -> tile flits, out_ready back-pressure
// Modports:
//   master : tile side (drives in_* flits and out_ready)
//   slave  : loopback side (drives in_ready and out_* flits)
// -----------------------------------------------------------------------------
interface soc_noc_loopback_if #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 32
);
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
    logic [CHANNELS-1:0]                 in_last;
    logic [CHANNELS-1:0]                 in_valid;
    logic [CHANNELS-1:0]                 in_ready;
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0] out_flit;
    logic [CHANNELS-1:0]                 out_last;
    logic [CHANNELS-1:0]                 out_valid;
    logic [CHANNELS-1:0]                 out_ready;

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid
    );

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid
    );
endinterface

// File: rtl/soc_noc_loopback.sv
// -----------------------------------------------------------------------------
// soc_noc_loopback
// Per-channel store-and-forward loopback of NoC packets. Each channel buffers
// a packet in its own FIFO and returns it once its last flit is stored; a
// packet larger than the FIFO starts cut-through when the FIFO fills. Header
// flits optionally come back with dest/src IDs exchanged.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : gates acceptance of new packets and start of new output packets
//   noc        : flit handshake bundle (slave modport)
//   pkt_count  : per-channel count of fully returned packets, saturating
// -----------------------------------------------------------------------------
module soc_noc_loopback #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int SWAP_IDS   = 1,
    parameter int ID_BITS    = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    soc_noc_loopback_if.slave          noc,
    output logic [CHANNELS-1:0][15:0]  pkt_count
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    // Holds in_ready low until the first clock edge after reset release.
    logic rst_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    logic [CHANNELS-1:0]                 in_ready_v;
    logic [CHANNELS-1:0]                 out_valid_v;
    logic [CHANNELS-1:0]                 out_last_v;
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0] out_flit_v;

    assign noc.in_ready  = in_ready_v;
    assign noc.out_valid = out_valid_v;
    assign noc.out_last  = out_last_v;
    assign noc.out_flit  = out_flit_v;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [FLIT_WIDTH:0]   mem [DEPTH];
        logic [AW-1:0]         wr_ptr, rd_ptr;
        logic [AW:0]           occ, complete;
        logic                  in_mid, out_mid, out_hdr;
        logic [15:0]           pkt_cnt;
        logic                  wr_en, rd_en, wr_last, rd_last, out_active;
        logic [FLIT_WIDTH:0]   head;
        logic [FLIT_WIDTH-1:0] head_flit;

        assign head    = mem[rd_ptr];
        assign wr_en   = noc.in_valid[c] & in_ready_v[c];
        assign rd_en   = out_valid_v[c] & noc.out_ready[c];
        assign wr_last = wr_en & noc.in_last[c];
        assign rd_last = rd_en & head[FLIT_WIDTH];

        // A started packet keeps going regardless of enable; a new one needs
        // enable plus either a complete stored packet or a full FIFO (the
        // latter is the cut-through case for oversize packets).
        assign out_active = out_mid | (enable & ((complete != '0) | (occ == FULL)));

        assign in_ready_v[c]  = rst_done & (occ < FULL) & (enable | in_mid);
        assign out_valid_v[c] = rst_done & out_active & (occ != '0);
        assign out_last_v[c]  = out_valid_v[c] & head[FLIT_WIDTH];
        assign out_flit_v[c]  = out_valid_v[c] ? head_flit : '0;
        assign pkt_count[c]   = pkt_cnt;

        always_comb begin
            // NOTE: default assigned first so no path leaves head_flit unassigned (no latch).
            head_flit = head[FLIT_WIDTH-1:0];
            if (SWAP_IDS != 0 && out_hdr) begin
                head_flit[FLIT_WIDTH-1 -: ID_BITS] = head[FLIT_WIDTH-9 -: ID_BITS];
                head_flit[FLIT_WIDTH-9 -: ID_BITS] = head[FLIT_WIDTH-1 -: ID_BITS];
            end
        end

        // NOTE: flit storage is deliberately not reset; occupancy and pointers
        // decide what is valid, so stale contents are never observed.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= {noc.in_last[c], noc.in_flit[c]};
        end

        // NOTE: all state below uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                complete <= '0;
                in_mid   <= 1'b0;
                out_mid  <= 1'b0;
                out_hdr  <= 1'b1;
                pkt_cnt  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    in_mid <= ~noc.in_last[c];
                end
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    out_hdr <= head[FLIT_WIDTH];
                end
                occ      <= occ + (AW+1)'(wr_en) - (AW+1)'(rd_en);
                complete <= complete + (AW+1)'(wr_last) - (AW+1)'(rd_last);
                // Once valid is shown the packet is committed until its last flit leaves.
                out_mid  <= out_active & ~rd_last;
                if (rd_last && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_soc_noc_loopback.sv
// -----------------------------------------------------------------------------
// tb_soc_noc_loopback
// Directed bench for soc_noc_loopback (CHANNELS=2, FLIT_WIDTH=32, DEPTH=16,
// SWAP_IDS=1). Accepted input flits are pushed to a per-channel scoreboard
// (header IDs swapped by the bench's own field model) and popped when the
// DUT returns a flit.
// -----------------------------------------------------------------------------
module tb_soc_noc_loopback;
    localparam int CH = 2;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic [CH-1:0][15:0] pkt_count;

    soc_noc_loopback_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) nif ();

    soc_noc_loopback #(
        .CHANNELS(CH), .FLIT_WIDTH(FW), .DEPTH(16), .SWAP_IDS(1), .ID_BITS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .noc(nif.slave), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    always @(posedge clk) cycle++;

    logic [FW:0] sbq [CH][$];
    logic        hdr_model [CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // dest is bits [31:27], src is bits [23:19]
    function automatic logic [FW-1:0] swap_ids(input logic [FW-1:0] f);
        logic [FW-1:0] r;
        r = f;
        r[31:27] = f[23:19];
        r[23:19] = f[31:27];
        return r;
    endfunction

    // Output monitor: pops the scoreboard on every returned flit.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rst_n && nif.out_valid[c] && nif.out_ready[c]) begin
                if (sbq[c].size() == 0) begin
                    check($sformatf("ch%0d_spurious_out", c), 64'(sbq[c].size()), 64'd1);
                end else begin
                    logic [FW:0] e;
                    e = sbq[c].pop_front();
                    check($sformatf("ch%0d_flit", c), 64'({nif.out_last[c], nif.out_flit[c]}), 64'(e));
                end
            end
        end
    end

    // Drives one flit; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send_flit(input int c, input logic [FW-1:0] f, input logic l);
        bit done;
        done = 1'b0;
        nif.in_flit[c]  = f;
        nif.in_last[c]  = l;
        nif.in_valid[c] = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (nif.in_ready[c]) begin
                sbq[c].push_back({l, hdr_model[c] ? swap_ids(f) : f});
                hdr_model[c] = l;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        nif.in_valid[c] = 1'b0;
        check($sformatf("ch%0d_send_accept", c), 64'(done), 64'd1);
    endtask

    task automatic send_pkt(input int c, input logic [FW-1:0] hdr, input int n);
        for (int i = 0; i < n; i++) begin
            logic [FW-1:0] f;
            f = (i == 0) ? hdr : (32'hA000_0000 | (32'(c) << 16) | 32'(i));
            send_flit(c, f, i == n - 1);
        end
    endtask

    task automatic drain(input int c);
        for (int k = 0; k < 600 && sbq[c].size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
        check($sformatf("ch%0d_drained", c), 64'(sbq[c].size()), 64'd0);
    endtask

    initial begin
        int t0, ch1_cycles;
        logic [FW-1:0] f;

        nif.in_flit   = '0;
        nif.in_last   = '0;
        nif.in_valid  = '0;
        nif.out_ready = '1;
        for (int c = 0; c < CH; c++) hdr_model[c] = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", 64'(nif.in_ready), 64'd0);
        check("rst_out_valid", 64'(nif.out_valid), 64'd0);
        check("rst_out_flit", 64'(nif.out_flit), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(nif.in_ready), 64'd0);
        @(posedge clk); #1;
        check("in_ready_after_edge", 64'(nif.in_ready), 64'd3);

        // 3-flit packet on ch0: one-cycle latency, swapped header
        send_pkt(0, 32'h0800_0000, 3);
        @(negedge clk);
        check("ch0_latency_valid", 64'(nif.out_valid[0]), 64'd1);
        check("ch0_hdr_swapped", 64'(nif.out_flit[0]), 64'h0008_0000);
        drain(0);
        check("ch0_pkt_count_1", 64'(pkt_count[0]), 64'd1);

        // 16 single-flit packets on ch1 with output stalled
        nif.out_ready[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f = '0;
            f[31:27] = 5'(i);
            f[23:19] = 5'(i + 3);
            f[7:0]   = 8'(i);
            send_pkt(1, f, 1);
        end
        @(negedge clk);
        check("ch1_full_in_ready", 64'(nif.in_ready[1]), 64'd0);
        check("ch1_stalled_queue", 64'(sbq[1].size()), 64'd16);
        @(posedge clk); #1;
        nif.out_ready[1] = 1'b1;
        drain(1);
        check("ch1_pkt_count_16", 64'(pkt_count[1]), 64'd16);

        // Oversize 40-flit packet on ch0: must cut through without deadlock
        send_pkt(0, 32'h1810_0000, 40);
        drain(0);
        check("ch0_pkt_count_2", 64'(pkt_count[0]), 64'd2);

        // enable dropped mid-packet
        send_flit(0, 32'h2000_0000, 1'b0);
        enable = 1'b0;
        send_flit(0, 32'hA000_0001, 1'b0);
        send_flit(0, 32'hA000_0002, 1'b1);
        nif.in_flit[0]  = 32'h2800_0000;
        nif.in_last[0]  = 1'b0;
        nif.in_valid[0] = 1'b1;
        @(negedge clk);
        check("en_low_refuse", 64'(nif.in_ready[0]), 64'd0);
        check("en_low_no_start", 64'(nif.out_valid[0]), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("en_low_refuse_2", 64'(nif.in_ready[0]), 64'd0);
        nif.in_valid[0] = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        send_pkt(0, 32'h2800_0000, 2);
        drain(0);
        check("ch0_pkt_count_4", 64'(pkt_count[0]), 64'd4);

        // Reset with 5 flits buffered on ch1
        nif.out_ready[1] = 1'b0;
        send_pkt(1, 32'h3000_0000, 5);
        @(negedge clk);
        check("pre_rst_valid", 64'(nif.out_valid[1]), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(nif.out_valid), 64'd0);
        check("mid_rst_out_last", 64'(nif.out_last), 64'd0);
        check("mid_rst_out_flit", 64'(nif.out_flit), 64'd0);
        check("mid_rst_in_ready", 64'(nif.in_ready), 64'd0);
        check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
        for (int c = 0; c < CH; c++) begin
            sbq[c].delete();
            hdr_model[c] = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        nif.out_ready[1] = 1'b1;
        @(posedge clk); #1;
        send_pkt(1, 32'h3810_0000, 2);
        drain(1);
        check("post_rst_pkt_count1", 64'(pkt_count[1]), 64'd1);
        check("post_rst_pkt_count0", 64'(pkt_count[0]), 64'd0);

        // Both channels busy, ch0 output stalled
        nif.out_ready[0] = 1'b0;
        ch1_cycles = 0;
        fork
            begin
                send_pkt(0, 32'h4000_0000, 4);
                send_pkt(0, 32'h4800_0000, 4);
            end
            begin
                t0 = cycle;
                for (int p = 0; p < 8; p++) send_pkt(1, 32'h5000_0000 | (32'(p) << 19), 3);
                ch1_cycles = cycle - t0;
            end
        join
        check("ch1_throughput", 64'(ch1_cycles), 64'd24);
        drain(1);
        check("ch1_pkt_count_9", 64'(pkt_count[1]), 64'd9);
        @(negedge clk);
        check("ch0_stalled_valid", 64'(nif.out_valid[0]), 64'd1);
        check("ch0_stalled_queue", 64'(sbq[0].size()), 64'd8);
        @(posedge clk); #1;
        nif.out_ready[0] = 1'b1;
        drain(0);
        check("ch0_pkt_count_2b", 64'(pkt_count[0]), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
